// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the 8-bit PC, drives the synchronous instruction ROM and
// registers the fetched word plus its address, squashing wrong-path fetches on redirect.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_mux_sel,
  input  logic [7:0]  jmp_loc,
  input  logic        stall,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [23:0] rom_data,
  output logic [23:0] ins,
  output logic [7:0]  Current_Address,
  output logic        ins_valid
);

  localparam logic [23:0] NOP = 24'h000000;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_pc_q, w_pc_q;
  logic [7:0]  r_addr_q, w_addr_q;
  logic [23:0] w_ins;
  logic [7:0]  w_cur_addr;
  logic        w_ins_valid;

  assign rom_addr = r_pc_q;
  assign rom_en   = reset & ~stall;

  always_comb begin
    w_state     = r_state;
    w_pc_q      = r_pc_q;
    w_addr_q    = r_addr_q;
    w_ins       = ins;
    w_cur_addr  = Current_Address;
    w_ins_valid = ins_valid;
    if (!stall) begin
      case (r_state)
        BOOT: begin
          w_addr_q = r_pc_q;
          w_pc_q   = r_pc_q + 8'd1;
          w_state  = RUN;
        end
        RUN: begin
          if (pc_mux_sel) begin
            w_ins       = NOP;
            w_ins_valid = 1'b0;
            w_pc_q      = jmp_loc;
            w_state     = FLUSH;
          end else begin
            w_ins       = rom_data;
            w_ins_valid = 1'b1;
            w_cur_addr  = r_addr_q;
            w_addr_q    = r_pc_q;
            w_pc_q      = r_pc_q + 8'd1;
          end
        end
        FLUSH: begin
          // rom_data here belongs to the pre-redirect path and is dropped
          w_ins       = NOP;
          w_ins_valid = 1'b0;
          if (pc_mux_sel) begin
            w_pc_q = jmp_loc;
          end else begin
            w_addr_q = r_pc_q;
            w_pc_q   = r_pc_q + 8'd1;
            w_state  = RUN;
          end
        end
        default: w_state = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= BOOT;
      r_pc_q          <= 8'h00;
      r_addr_q        <= 8'h00;
      ins             <= NOP;
      Current_Address <= 8'h00;
      ins_valid       <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_pc_q          <= w_pc_q;
      r_addr_q        <= w_addr_q;
      ins             <= w_ins;
      Current_Address <= w_cur_addr;
      ins_valid       <= w_ins_valid;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: synchronous ROM model, bubble-counting
// reference model compared every cycle, plus directed literal checks.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_mux_sel = 1'b0;
  logic [7:0]  jmp_loc = 8'h00;
  logic        stall = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [23:0] rom_data = 24'h000000;
  logic [23:0] ins;
  logic [7:0]  Current_Address;
  logic        ins_valid;

  int n_err = 0;
  int n_chk = 0;
  bit cmp_en = 1'b0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
    .stall(stall), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .ins(ins), .Current_Address(Current_Address), .ins_valid(ins_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mem(input logic [7:0] a);
    return 24'h0A0000 + {16'h0000, a};
  endfunction

  // Synchronous ROM: output reflects the address sampled at the last enabled edge
  always @(posedge clk) if (rom_en) rom_data <= mem(rom_addr);

  // Reference model: a redirect kills everything in flight and costs two bubbles;
  // otherwise one word is delivered per unstalled edge after a one-edge boot.
  bit         m_boot = 1'b1;
  bit         m_bub  = 1'b0;
  logic [7:0] m_dlv  = 8'h00;
  logic [23:0] e_ins = 24'h0;
  logic [7:0]  e_ca  = 8'h00;
  logic        e_vld = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_boot = 1'b1; m_bub = 1'b0; m_dlv = 8'h00;
      e_ins = 24'h0; e_ca = 8'h00; e_vld = 1'b0;
    end else if (!stall) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (pc_mux_sel) begin
        e_ins = 24'h0; e_vld = 1'b0; m_bub = 1'b1; m_dlv = jmp_loc;
      end else if (m_bub) begin
        m_bub = 1'b0;
      end else begin
        e_ins = mem(m_dlv); e_ca = m_dlv; e_vld = 1'b1; m_dlv = m_dlv + 8'd1;
      end
    end
  end

  function automatic logic [7:0] exp_rom_addr();
    if (m_boot) return 8'h00;
    return m_bub ? m_dlv : m_dlv + 8'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_ins", {8'h0, ins}, {8'h0, e_ins});
      chk("model_ca", {24'h0, Current_Address}, {24'h0, e_ca});
      chk("model_vld", {31'h0, ins_valid}, {31'h0, e_vld});
      chk("model_rom_addr", {24'h0, rom_addr}, {24'h0, exp_rom_addr()});
      chk("model_rom_en", {31'h0, rom_en}, {31'h0, reset & ~stall});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic lit(input string nm, input logic [23:0] i, input logic [7:0] ca, input logic v);
    chk({nm, "_ins"}, {8'h0, ins}, {8'h0, i});
    chk({nm, "_ca"}, {24'h0, Current_Address}, {24'h0, ca});
    chk({nm, "_vld"}, {31'h0, ins_valid}, {31'h0, v});
  endtask

  logic [7:0] held_ca;
  logic [7:0] held_rom;

  initial begin
    cyc(3);
    lit("reset", 24'h000000, 8'h00, 1'b0);
    chk("reset_rom_addr", {24'h0, rom_addr}, 32'h0);
    chk("reset_rom_en", {31'h0, rom_en}, 32'h0);
    cmp_en = 1'b1;

    // Boot from address 0
    reset = 1'b1;
    cyc(1);
    lit("boot_e0", 24'h000000, 8'h00, 1'b0);
    cyc(1);
    lit("boot_e1", 24'h0A0000, 8'h00, 1'b1);
    cyc(1);
    lit("boot_e2", 24'h0A0001, 8'h01, 1'b1);
    cyc(1);
    lit("boot_e3", 24'h0A0002, 8'h02, 1'b1);
    cyc(3);
    lit("run_ca5", 24'h0A0005, 8'h05, 1'b1);

    // Jump to 0x40 while Current_Address = 5
    pc_mux_sel = 1'b1; jmp_loc = 8'h40;
    cyc(1);
    pc_mux_sel = 1'b0;
    lit("jmp_r", 24'h000000, 8'h05, 1'b0);
    cyc(1);
    lit("jmp_r1", 24'h000000, 8'h05, 1'b0);
    cyc(1);
    lit("jmp_r2", 24'h0A0040, 8'h40, 1'b1);
    cyc(1);
    lit("jmp_r3", 24'h0A0041, 8'h41, 1'b1);

    // Wrap through 0xFF -> 0x00
    pc_mux_sel = 1'b1; jmp_loc = 8'hFC;
    cyc(1);
    pc_mux_sel = 1'b0;
    cyc(3);
    lit("wrap_fd", 24'h0A00FD, 8'hFD, 1'b1);
    cyc(1);
    lit("wrap_fe", 24'h0A00FE, 8'hFE, 1'b1);
    cyc(1);
    lit("wrap_ff", 24'h0A00FF, 8'hFF, 1'b1);
    cyc(1);
    lit("wrap_00", 24'h0A0000, 8'h00, 1'b1);

    // Redirect to 0xFF: PC wraps inside FLUSH
    pc_mux_sel = 1'b1; jmp_loc = 8'hFF;
    cyc(1);
    pc_mux_sel = 1'b0;
    cyc(2);
    lit("jff_r2", 24'h0A00FF, 8'hFF, 1'b1);
    cyc(1);
    lit("jff_r3", 24'h0A0000, 8'h00, 1'b1);
    cyc(2);

    // Stall 3 cycles with a redirect pulse that must be ignored
    held_ca = Current_Address;
    held_rom = rom_addr;
    stall = 1'b1; pc_mux_sel = 1'b1; jmp_loc = 8'h77;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("stall_ca", {24'h0, Current_Address}, {24'h0, held_ca});
      chk("stall_rom_addr", {24'h0, rom_addr}, {24'h0, held_rom});
      chk("stall_rom_en", {31'h0, rom_en}, 32'h0);
    end
    stall = 1'b0; pc_mux_sel = 1'b0;
    cyc(1);
    lit("stall_rel", mem(held_ca + 8'd1), held_ca + 8'd1, 1'b1);
    cyc(1);
    lit("stall_rel2", mem(held_ca + 8'd2), held_ca + 8'd2, 1'b1);

    // Back-to-back redirect: 0x20 is overridden by 0xF0 while flushing
    pc_mux_sel = 1'b1; jmp_loc = 8'h20;
    cyc(1);
    jmp_loc = 8'hF0;
    cyc(1);
    pc_mux_sel = 1'b0;
    lit("b2b_r", 24'h000000, held_ca + 8'd2, 1'b0);
    cyc(1);
    lit("b2b_r1", 24'h000000, held_ca + 8'd2, 1'b0);
    cyc(1);
    lit("b2b_r2", 24'h0A00F0, 8'hF0, 1'b1);
    cyc(1);
    lit("b2b_r3", 24'h0A00F1, 8'hF1, 1'b1);

    // Asynchronous reset while in FLUSH
    pc_mux_sel = 1'b1; jmp_loc = 8'h30;
    @(posedge clk);
    #2;
    pc_mux_sel = 1'b0;
    reset = 1'b0;
    #1;
    lit("areset", 24'h000000, 8'h00, 1'b0);
    chk("areset_rom_addr", {24'h0, rom_addr}, 32'h0);
    chk("areset_rom_en", {31'h0, rom_en}, 32'h0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    lit("reboot_e1", 24'h0A0000, 8'h00, 1'b1);
    cyc(1);
    lit("reboot_e2", 24'h0A0001, 8'h01, 1'b1);
    cyc(2);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
